acquisition_sequencer: RTL and testbench

Sequences one single-pixel-imaging acquisition run: per projected pattern it waits for the DMD pattern trigger, clears and gates the photon counter for a programmed integration window, latches the count and hands it to the readout path over a valid/ready handshake. Configured and started by 16-bit commands from the SPI slave. Sits between the SPI command decoder, the photon counter and the readout FIFO/SPI transmitter.

---
 rtl/acquisition_sequencer_pkg.sv | 24 ++
 rtl/acquisition_sequencer_cmd_decoder.sv | 61 ++++++
 rtl/acquisition_sequencer.sv | 143 ++++++++++++++
 tb/tb_acquisition_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/acquisition_sequencer_pkg.sv
// Shared definitions for the single-pixel acquisition sequencer: opcodes,
// FSM state encoding and configuration defaults.
package acq_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_GATE_LO = 4'h1;
  localparam logic [3:0] OP_GATE_HI = 4'h2;
  localparam logic [3:0] OP_NPAT    = 4'h3;
  localparam logic [3:0] OP_START   = 4'h4;
  localparam logic [3:0] OP_ABORT   = 4'h5;

  localparam int GATE_LEN_DEF = 1;
  localparam int N_PAT_DEF    = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_CLEAR = 3'd2,
    S_GATE  = 3'd3,
    S_LATCH = 3'd4,
    S_OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/acquisition_sequencer_cmd_decoder.sv
// Decodes 16-bit SPI command words into the gate length / pattern count
// registers and one-cycle start/abort strobes.
module cmd_decoder
  import acq_pkg::*;
#(
  parameter int GATE_W = 24,
  parameter int IDX_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       cmd_i,
  input  logic              cmd_valid_i,
  input  logic              busy_i,
  output logic [GATE_W-1:0] gate_len_o,
  output logic [IDX_W-1:0]  n_pat_o,
  output logic              start_o,
  output logic              abort_o
);

  logic [3:0]        op;
  logic [11:0]       arg;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [IDX_W-1:0]  n_pat_q, n_pat_d;
  logic              cfg_we;

  assign op  = cmd_i[15:12];
  assign arg = cmd_i[11:0];

  // Configuration and START are locked out for the whole run; ABORT never is.
  assign cfg_we = cmd_valid_i && !busy_i;

  always_comb begin
    gate_len_d = gate_len_q;
    n_pat_d    = n_pat_q;
    if (cfg_we) begin
      case (op)
        OP_NOP:     ;
        OP_GATE_LO: gate_len_d[11:0]        = arg;
        OP_GATE_HI: gate_len_d[GATE_W-1:12] = arg[GATE_W-13:0];
        OP_NPAT:    n_pat_d                 = arg[IDX_W-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_len_q <= GATE_W'(GATE_LEN_DEF);
      n_pat_q    <= IDX_W'(N_PAT_DEF);
    end else begin
      gate_len_q <= gate_len_d;
      n_pat_q    <= n_pat_d;
    end
  end

  assign gate_len_o = gate_len_q;
  assign n_pat_o    = n_pat_q;
  assign start_o    = cfg_we && (op == OP_START);
  assign abort_o    = cmd_valid_i && (op == OP_ABORT);

endmodule

// File: rtl/acquisition_sequencer.sv
// Per-pattern acquisition sequencer: wait trigger, clear and gate the photon
// counter, latch the count and hand it to readout over valid/ready.
module acquisition_sequencer
  import acq_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 24,
  parameter int IDX_W  = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      CMD,
  input  logic             CMD_VALID,
  input  logic             TRIG,
  input  logic [CNT_W-1:0] PHOTON_COUNT,
  output logic             COUNT_CLEAR,
  output logic             START_COUNT,
  output logic [CNT_W-1:0] DATA_OUT,
  output logic [IDX_W-1:0] DATA_IDX,
  output logic             DATA_VALID,
  input  logic             DATA_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR_OVERRUN
);

  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_len, gate_eff;
  logic [IDX_W-1:0]  n_pat;
  logic              start, abort;
  logic              trig_q, trig_evt;
  logic              last_pat, accept;
  logic [GATE_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  dout_q, dout_d;
  logic [IDX_W-1:0]  didx_q, didx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  cmd_decoder #(
    .GATE_W(GATE_W),
    .IDX_W (IDX_W)
  ) u_cmd (
    .clk_i      (CLK),
    .rst_i      (RST),
    .cmd_i      (CMD),
    .cmd_valid_i(CMD_VALID),
    .busy_i     (BUSY),
    .gate_len_o (gate_len),
    .n_pat_o    (n_pat),
    .start_o    (start),
    .abort_o    (abort)
  );

  assign gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;
  assign trig_evt = TRIG && !trig_q;
  assign last_pat = (idx_q == n_pat - IDX_W'(1));
  assign accept   = (state_q == S_OUT) && DATA_READY && !abort;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && n_pat != '0) state_d = S_ARM;
        S_ARM:   if (trig_evt) state_d = S_CLEAR;
        S_CLEAR: state_d = S_GATE;
        S_GATE:  if (gcnt_q == GATE_W'(1)) state_d = S_LATCH;
        S_LATCH: state_d = S_OUT;
        S_OUT:   if (DATA_READY) state_d = last_pat ? S_IDLE : S_ARM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    COUNT_CLEAR = (state_q == S_CLEAR);
    START_COUNT = (state_q == S_GATE);
    DATA_VALID  = (state_q == S_OUT);
    BUSY        = (state_q != S_IDLE);
  end

  always_comb begin
    gcnt_d = gcnt_q;
    idx_d  = idx_q;
    dout_d = dout_q;
    didx_d = didx_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (start) begin
      err_d  = 1'b0;
      idx_d  = '0;
      done_d = (n_pat == '0);
    end
    // Triggers outside ARM are dropped; only the flag records them.
    if (trig_evt && state_q != S_IDLE && state_q != S_ARM) err_d = 1'b1;
    case (state_q)
      S_CLEAR: gcnt_d = gate_eff;
      S_GATE:  gcnt_d = gcnt_q - GATE_W'(1);
      S_LATCH: begin
        dout_d = PHOTON_COUNT;
        didx_d = idx_q;
      end
      default: ;
    endcase
    if (accept) begin
      if (last_pat) done_d = 1'b1;
      else          idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trig_q <= 1'b0;
      gcnt_q <= '0;
      idx_q  <= '0;
      dout_q <= '0;
      didx_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      trig_q <= TRIG;
      gcnt_q <= gcnt_d;
      idx_q  <= idx_d;
      dout_q <= dout_d;
      didx_q <= didx_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign DATA_IDX    = didx_q;
  assign DONE        = done_q;
  assign ERR_OVERRUN = err_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Directed bench for acquisition_sequencer with a behavioural photon counter.
module tb_acquisition_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] CMD = '0;
  logic        CMD_VALID = 1'b0;
  logic        TRIG = 1'b0;
  logic [31:0] PHOTON_COUNT;
  logic        COUNT_CLEAR, START_COUNT, DATA_VALID, BUSY, DONE, ERR_OVERRUN;
  logic [31:0] DATA_OUT;
  logic [11:0] DATA_IDX;
  logic        DATA_READY = 1'b1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  acquisition_sequencer dut (
    .CLK(CLK), .RST(RST), .CMD(CMD), .CMD_VALID(CMD_VALID), .TRIG(TRIG),
    .PHOTON_COUNT(PHOTON_COUNT), .COUNT_CLEAR(COUNT_CLEAR),
    .START_COUNT(START_COUNT), .DATA_OUT(DATA_OUT), .DATA_IDX(DATA_IDX),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .BUSY(BUSY),
    .DONE(DONE), .ERR_OVERRUN(ERR_OVERRUN)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              PHOTON_COUNT <= '0;
    else if (COUNT_CLEAR) PHOTON_COUNT <= '0;
    else if (START_COUNT) PHOTON_COUNT <= PHOTON_COUNT + 32'd1;
  end

  task automatic send(input logic [3:0] op, input logic [11:0] arg);
    @(negedge CLK);
    CMD = {op, arg};
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    CMD = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Fires one trigger and records what the sequencer does for that pattern.
  task automatic run_pat(input int maxc, output int n_clr, output int n_sc,
                         output int n_done, output int lat,
                         output logic [31:0] d, output logic [11:0] ix);
    n_clr = 0; n_sc = 0; n_done = 0; lat = -1; d = '0; ix = '0;
    @(negedge CLK);
    TRIG = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge CLK);
      if (k == 1) TRIG = 1'b0;
      n_clr  += int'(COUNT_CLEAR);
      n_sc   += int'(START_COUNT);
      n_done += int'(DONE);
      if (DATA_VALID && lat < 0) begin
        lat = k; d = DATA_OUT; ix = DATA_IDX;
      end
      if (lat >= 0 && k >= lat + 2) break;
    end
  endtask

  task automatic test_reset;
    wait_cyc(2);
    tot_cnt++;
    if ({COUNT_CLEAR, START_COUNT, DATA_VALID, BUSY, DONE, ERR_OVERRUN, DATA_OUT, DATA_IDX} !== '0)
      $display("FAIL reset_outputs: got cc=%b sc=%b v=%b busy=%b done=%b err=%b d=%0d ix=%0d want all 0",
               COUNT_CLEAR, START_COUNT, DATA_VALID, BUSY, DONE, ERR_OVERRUN, DATA_OUT, DATA_IDX);
    else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int nc, ns, nd, lat; logic [31:0] d; logic [11:0] ix;
    send(4'h1, 12'd5); send(4'h3, 12'd3); send(4'h4, 12'd0);
    tot_cnt++;
    if (BUSY !== 1'b1) $display("FAIL basic_busy: got %b want 1", BUSY); else pass_cnt++;
    for (int p = 0; p < 3; p++) begin
      wait_cyc(12);
      run_pat(40, nc, ns, nd, lat, d, ix);
      tot_cnt++; if (nc != 1) $display("FAIL basic_clr p%0d: got %0d want 1", p, nc); else pass_cnt++;
      tot_cnt++; if (ns != 5) $display("FAIL basic_gate p%0d: got %0d want 5", p, ns); else pass_cnt++;
      tot_cnt++; if (lat != 8) $display("FAIL basic_latency p%0d: got %0d want 8", p, lat); else pass_cnt++;
      tot_cnt++; if (d !== 32'd5) $display("FAIL basic_data p%0d: got %0d want 5", p, d); else pass_cnt++;
      tot_cnt++; if (ix !== 12'(p)) $display("FAIL basic_idx p%0d: got %0d want %0d", p, ix, p); else pass_cnt++;
      tot_cnt++;
      if (nd != ((p == 2) ? 1 : 0)) $display("FAIL basic_done p%0d: got %0d want %0d", p, nd, (p == 2) ? 1 : 0);
      else pass_cnt++;
    end
    tot_cnt++;
    if (BUSY !== 1'b0) $display("FAIL basic_idle: got busy=%b want 0", BUSY); else pass_cnt++;
  endtask

  task automatic test_long_gate;
    int nc, ns, nd, lat; logic [31:0] d; logic [11:0] ix;
    send(4'h1, 12'h100); send(4'h2, 12'h000); send(4'h3, 12'd1); send(4'h4, 12'd0);
    run_pat(300, nc, ns, nd, lat, d, ix);
    tot_cnt++; if (ns != 256) $display("FAIL long_gate: got %0d want 256", ns); else pass_cnt++;
    tot_cnt++; if (d !== 32'd256) $display("FAIL long_data: got %0d want 256", d); else pass_cnt++;
    tot_cnt++; if (lat != 259) $display("FAIL long_latency: got %0d want 259", lat); else pass_cnt++;
    tot_cnt++; if (nd != 1) $display("FAIL long_done: got %0d want 1", nd); else pass_cnt++;
  endtask

  task automatic test_stall;
    int nc, ns, nd, lat, bad, seen; logic [31:0] d, d0; logic [11:0] ix;
    send(4'h1, 12'd5); send(4'h2, 12'd0); send(4'h3, 12'd2); send(4'h4, 12'd0);
    DATA_READY = 1'b0;
    @(negedge CLK); TRIG = 1'b1;
    @(negedge CLK); TRIG = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge CLK);
      if (DATA_VALID) seen = 1;
    end
    tot_cnt++; if (seen != 1) $display("FAIL stall_valid_timeout: got %0d want 1", seen); else pass_cnt++;
    d0 = DATA_OUT;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (i == 20) TRIG = 1'b1;
      if (i == 21) TRIG = 1'b0;
      if (!DATA_VALID || DATA_OUT !== d0) bad++;
    end
    tot_cnt++; if (d0 !== 32'd5) $display("FAIL stall_data: got %0d want 5", d0); else pass_cnt++;
    tot_cnt++; if (bad != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); else pass_cnt++;
    tot_cnt++; if (ERR_OVERRUN !== 1'b1) $display("FAIL stall_overrun: got %b want 1", ERR_OVERRUN); else pass_cnt++;
    DATA_READY = 1'b1;
    @(negedge CLK);
    tot_cnt++;
    if ({DATA_VALID, BUSY} !== 2'b01) $display("FAIL stall_accept: got v=%b busy=%b want v=0 busy=1", DATA_VALID, BUSY);
    else pass_cnt++;
    wait_cyc(3);
    run_pat(40, nc, ns, nd, lat, d, ix);
    tot_cnt++; if (ix !== 12'd1) $display("FAIL stall_idx2: got %0d want 1", ix); else pass_cnt++;
    tot_cnt++; if (nd != 1) $display("FAIL stall_done: got %0d want 1", nd); else pass_cnt++;
    tot_cnt++; if (ERR_OVERRUN !== 1'b1) $display("FAIL stall_sticky: got %b want 1", ERR_OVERRUN); else pass_cnt++;
    send(4'h4, 12'd0);
    tot_cnt++; if (ERR_OVERRUN !== 1'b0) $display("FAIL stall_clear_err: got %b want 0", ERR_OVERRUN); else pass_cnt++;
    send(4'h5, 12'd0);
    tot_cnt++; if (BUSY !== 1'b0) $display("FAIL stall_abort_idle: got %b want 0", BUSY); else pass_cnt++;
  endtask

  task automatic test_abort;
    int nc, ns, nd, lat, nv, ndn, nsc; logic [31:0] d; logic [11:0] ix;
    send(4'h1, 12'd100); send(4'h3, 12'd1); send(4'h4, 12'd0);
    @(negedge CLK); TRIG = 1'b1;
    @(negedge CLK); TRIG = 1'b0;
    wait_cyc(40);
    tot_cnt++; if (START_COUNT !== 1'b1) $display("FAIL abort_in_gate: got %b want 1", START_COUNT); else pass_cnt++;
    send(4'h5, 12'd0);
    tot_cnt++;
    if ({START_COUNT, BUSY, DATA_VALID} !== 3'b000)
      $display("FAIL abort_next: got sc=%b busy=%b v=%b want 0", START_COUNT, BUSY, DATA_VALID);
    else pass_cnt++;
    nv = 0; ndn = 0; nsc = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      nv += int'(DATA_VALID); ndn += int'(DONE); nsc += int'(START_COUNT);
    end
    tot_cnt++;
    if (nv + ndn + nsc != 0) $display("FAIL abort_quiet: got v=%0d done=%0d sc=%0d want 0", nv, ndn, nsc);
    else pass_cnt++;
    send(4'h4, 12'd0);
    run_pat(150, nc, ns, nd, lat, d, ix);
    tot_cnt++; if (ns != 100) $display("FAIL abort_rerun_gate: got %0d want 100", ns); else pass_cnt++;
    tot_cnt++; if (d !== 32'd100) $display("FAIL abort_rerun_data: got %0d want 100", d); else pass_cnt++;
    tot_cnt++; if (nd != 1) $display("FAIL abort_rerun_done: got %0d want 1", nd); else pass_cnt++;
  endtask

  task automatic test_npat0_busy_cfg;
    int nc, ns, nd, lat; logic [31:0] d; logic [11:0] ix;
    send(4'h3, 12'd0);
    send(4'h4, 12'd0);
    tot_cnt++;
    if ({DONE, BUSY, COUNT_CLEAR} !== 3'b100)
      $display("FAIL npat0_done: got done=%b busy=%b cc=%b want 1,0,0", DONE, BUSY, COUNT_CLEAR);
    else pass_cnt++;
    @(negedge CLK);
    tot_cnt++;
    if ({DONE, BUSY} !== 2'b00) $display("FAIL npat0_pulse: got done=%b busy=%b want 0,0", DONE, BUSY);
    else pass_cnt++;
    send(4'h1, 12'd3); send(4'h3, 12'd1); send(4'h4, 12'd0);
    send(4'h1, 12'd7);
    run_pat(40, nc, ns, nd, lat, d, ix);
    tot_cnt++; if (ns != 3) $display("FAIL busy_cfg_gate: got %0d want 3", ns); else pass_cnt++;
  endtask

  task automatic test_rst_mid;
    int nc, ns, nd, lat; logic [31:0] d; logic [11:0] ix;
    send(4'h1, 12'd10); send(4'h3, 12'd2); send(4'h4, 12'd0);
    @(negedge CLK); TRIG = 1'b1;
    @(negedge CLK); TRIG = 1'b0;
    wait_cyc(4);
    tot_cnt++; if (START_COUNT !== 1'b1) $display("FAIL rst_pre_gate: got %b want 1", START_COUNT); else pass_cnt++;
    #2 RST = 1'b1;
    #1;
    tot_cnt++;
    if ({COUNT_CLEAR, START_COUNT, DATA_VALID, BUSY, DONE, ERR_OVERRUN, DATA_OUT, DATA_IDX} !== '0)
      $display("FAIL rst_async: got sc=%b busy=%b v=%b d=%0d want all 0", START_COUNT, BUSY, DATA_VALID, DATA_OUT);
    else pass_cnt++;
    @(negedge CLK); RST = 1'b0;
    send(4'h4, 12'd0);
    run_pat(40, nc, ns, nd, lat, d, ix);
    tot_cnt++; if (ns != 1) $display("FAIL rst_default_gate: got %0d want 1", ns); else pass_cnt++;
    tot_cnt++; if (d !== 32'd1) $display("FAIL rst_default_data: got %0d want 1", d); else pass_cnt++;
    tot_cnt++; if (nd != 1) $display("FAIL rst_default_npat: got done=%0d want 1", nd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_gate();
    test_stall();
    test_abort();
    test_npat0_busy_cfg();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, tot_cnt);
    $fatal(1);
  end

endmodule
